bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter FRAME_LEN, default 84: number of cycles one node owns the bus per frame; legal range 1..255.
REQ-002 Parameter GAP_LEN, default 2: number of GAP-state cycles after each frame; legal range 0..255.
REQ-003 Port clock  input  1: the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 Port enable  input  1: when 1, new grants may be issued; when 0, no new frame starts.
REQ-006 Port req  input  16: transmit request, bit i = node i+1 has a frame pending.
REQ-007 Port mod  output  16: one-hot transmit select driven to the 16-node bus fabric; all-zero = bus idle.
REQ-008 Port cur_node  output  4: index 0..15 of the granted node; meaningful only while busy=1.
REQ-009 Port busy  output  1: 1 while a frame is in progress (GRANT state).
REQ-010 Port frame_start  output  1: one-cycle pulse on the first GRANT cycle of each frame.
REQ-011 Port frame_done  output  1: one-cycle pulse on the last GRANT cycle of each frame.

Function
REQ-012 The block SHALL implement three states: IDLE, GRANT, GAP; all outputs registered.
REQ-013 IDLE: if enable=1 and req!=0 at a clock edge, the block SHALL enter GRANT at that edge; otherwise it SHALL remain in IDLE.
REQ-014 Winner selection SHALL be round-robin: first set req bit scanning circularly from index ptr+1, where ptr is the index last granted.
REQ-015 On entering GRANT, the block SHALL set mod to one-hot(winner), cur_node to winner, busy to 1, frame_start to 1, and ptr to winner.
REQ-016 mod and cur_node SHALL stay constant for exactly FRAME_LEN cycles in GRANT, independent of req and enable changes.
REQ-017 frame_done SHALL be 1 only on the FRAME_LEN-th GRANT cycle; for FRAME_LEN=1, frame_start and frame_done SHALL both be 1 on the same cycle.
REQ-018 After the last GRANT cycle, the block SHALL enter GAP if GAP_LEN>0, otherwise IDLE; mod=0 and busy=0 outside GRANT.
REQ-019 GAP SHALL last exactly GAP_LEN cycles and then go to IDLE.
REQ-020 With requests continuously present, mod SHALL be all-zero for exactly GAP_LEN+1 cycles between consecutive frames.
REQ-021 The frame cycle counter SHALL be 8 bits, SHALL clear on every GRANT entry, and SHALL never wrap within a frame.
REQ-022 mod SHALL never have more than one bit set; ptr wrap from 15 SHALL continue the scan at 0.
REQ-023 A req bit dropped mid-frame SHALL NOT shorten the frame; a req bit raised mid-frame SHALL be considered only at the next IDLE evaluation.
REQ-024 enable=0 during GRANT or GAP SHALL let the frame and gap complete, then hold the block in IDLE.

Reset
REQ-025 When reset=1 at a clock edge: state=IDLE, mod=0, cur_node=0, busy=0, frame_start=0, frame_done=0, counter=0, ptr=15, so node 0 has first priority.
REQ-026 Reset SHALL take precedence over every other input, including mid-frame; the aborted frame SHALL NOT produce frame_done.

Verification
REQ-027 Single requester: reset, then req=0x0001, enable=1 held -> mod=0x0001 one cycle later, held 84 cycles, frame_done on cycle 84, mod=0 for 3 cycles, then re-granted 0x0001.
REQ-028 Rotation: req=0x000F held -> grant sequence 0x0001, 0x0002, 0x0004, 0x0008, 0x0001, with 3 idle cycles between frames.
REQ-029 Wrap: node 14 last granted, req=0x8001 -> next grant 0x8000 (cur_node=15), then 0x0001 (cur_node=0).
REQ-030 Mid-frame req drop: req=0x0004, cleared at GRANT cycle 10 -> mod=0x0004 still held 84 cycles, then IDLE with mod=0.
REQ-031 Reset mid-frame: reset=1 at GRANT cycle 40 -> mod=0, busy=0 on the next cycle and no frame_done; with req=0xFFFF after reset release -> first grant 0x0001.
REQ-032 Enable gating: enable=0 during a frame -> frame and gap complete, mod stays 0; enable=1 with req!=0 -> grant one cycle later.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter granting fixed-length frames to 16 nodes
// Frames are FRAME_LEN cycles long, followed by GAP_LEN idle cycles and one IDLE evaluation cycle.
module bus_arbiter #(
    parameter int FRAME_LEN = 84,
    parameter int GAP_LEN   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] req,
    output logic [15:0] mod,
    output logic [3:0]  cur_node,
    output logic        busy,
    output logic        frame_start,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Counter holds (cycle number - 1) within the current frame or gap.
    localparam logic [7:0] FRAME_LAST = 8'(FRAME_LEN - 1);
    localparam logic [7:0] GAP_LAST   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [15:0] mod_d;
    logic [3:0]  node_d;
    logic        busy_d;
    logic        start_d;
    logic        done_d;

    logic [3:0]  winner;
    logic        found;
    logic [3:0]  scan_idx;

    // Circular scan starting just after the last granted node; the last
    // granted node itself is examined last.
    always_comb begin
        winner   = ptr_q;
        found    = 1'b0;
        scan_idx = ptr_q;
        for (int i = 1; i <= 16; i++) begin
            scan_idx = ptr_q + 4'(i);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        mod_d   = mod;
        node_d  = cur_node;
        busy_d  = busy;
        start_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mod_d  = 16'd0;
                busy_d = 1'b0;
                if (enable && found) begin
                    state_d = ST_GRANT;
                    cnt_d   = 8'd0;
                    ptr_d   = winner;
                    mod_d   = 16'd1 << winner;
                    node_d  = winner;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    done_d  = (FRAME_LAST == 8'd0);
                end
            end

            ST_GRANT: begin
                if (cnt_q == FRAME_LAST) begin
                    mod_d   = 16'd0;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = (GAP_LEN > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    done_d = ((cnt_q + 8'd1) == FRAME_LAST);
                end
            end

            ST_GAP: begin
                mod_d  = 16'd0;
                busy_d = 1'b0;
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                mod_d   = 16'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            ptr_q       <= 4'd15;
            mod         <= 16'd0;
            cur_node    <= 4'd0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            mod         <= mod_d;
            cur_node    <= node_d;
            busy        <= busy_d;
            frame_start <= start_d;
            frame_done  <= done_d;
        end
    end

endmodule
